// File: rtl/burst_tone_gen.sv
// Gated square-wave burst generator driving the phased-delay shift-register chain.
// Optional macro TRIG_SYNC_EN adds a two-flop synchronizer on trig before edge detection.
module burst_tone_gen #(
  parameter int HALF_PERIOD  = 625,
  parameter int BURST_CYCLES = 8,
  parameter int GAP_CLKS     = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic continuous,
  input  logic trig,
  output logic pwm_out,
  output logic busy,
  output logic burst_start
);

  // cyc_cnt has to reach BURST_CYCLES itself, so it is sized for that value.
  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int CW = (BURST_CYCLES + 1 > 1) ? $clog2(BURST_CYCLES + 1) : 1;
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] CYC_DONE  = CW'(BURST_CYCLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [GW-1:0] gap_cnt;
  logic          trig_in;
  logic          trig_q;
  logic          trig_rise;

`ifdef TRIG_SYNC_EN
  logic trig_s1;
  logic trig_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
    end
  end

  assign trig_in = trig_s2;
`else
  assign trig_in = trig;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= 1'b0;
    else        trig_q <= trig_in;
  end

  assign trig_rise = trig_in & ~trig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pwm_out     <= 1'b0;
      busy        <= 1'b0;
      burst_start <= 1'b0;
      half_cnt    <= '0;
      cyc_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      burst_start <= 1'b0;
      case (state)
        IDLE: begin
          pwm_out <= 1'b0;
          busy    <= 1'b0;
          if (enable && (continuous || trig_rise)) begin
            state       <= BURST;
            pwm_out     <= 1'b1;
            busy        <= 1'b1;
            burst_start <= 1'b1;
            half_cnt    <= '0;
            cyc_cnt     <= '0;
          end
        end

        BURST: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (pwm_out) begin
              pwm_out <= 1'b0;
              cyc_cnt <= cyc_cnt + 1'b1;
            end else if (cyc_cnt == CYC_DONE) begin
              // The rising edge that would start an extra cycle becomes the gap entry.
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              pwm_out <= 1'b1;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        GAP: begin
          pwm_out <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            if (enable && continuous) begin
              state       <= BURST;
              pwm_out     <= 1'b1;
              burst_start <= 1'b1;
              half_cnt    <= '0;
              cyc_cnt     <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          pwm_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_tone_gen.sv
// Directed self-checking bench for burst_tone_gen with HALF_PERIOD=4, BURST_CYCLES=3, GAP_CLKS=10.
// Honours TRIG_SYNC_EN by shifting the expected trigger latency by two clocks.
module tb_burst_tone_gen;

  localparam int HP    = 4;
  localparam int BC    = 3;
  localparam int GAP   = 10;
  localparam int BLEN  = 2 * HP * BC;   // 24 clocks of tone
  localparam int TOTAL = BLEN + GAP;    // 34 clocks busy / repetition period
`ifdef TRIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst_n;
  logic enable;
  logic continuous;
  logic trig;
  logic pwm_out;
  logic busy;
  logic burst_start;

  int checks = 0;
  int errors = 0;

  burst_tone_gen #(
    .HALF_PERIOD (HP),
    .BURST_CYCLES(BC),
    .GAP_CLKS    (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .continuous (continuous),
    .trig       (trig),
    .pwm_out    (pwm_out),
    .busy       (busy),
    .burst_start(burst_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int k);
    check({tag, ".pwm"},   k, pwm_out,     1'b0);
    check({tag, ".busy"},  k, busy,        1'b0);
    check({tag, ".start"}, k, burst_start, 1'b0);
  endtask

  // Checks n cycles starting at the cycle right after a burst-start edge (k=0).
  // Expected waveform: 4 high / 4 low for 24 clocks, low for the 10-clock gap.
  task automatic window(input string tag, input int n, input bit cont, input bit hold,
                        input logic [63:0] pulses, input int en_drop_k);
    int  kk;
    bit  e_pwm;
    bit  e_busy;
    bit  e_start;
    for (int k = 0; k < n; k++) begin
      kk      = cont ? (k % TOTAL) : k;
      e_pwm   = (kk < BLEN) && ((kk % (2 * HP)) < HP);
      e_busy  = cont ? 1'b1 : (kk < TOTAL);
      e_start = (kk == 0);
      check({tag, ".pwm"},   k, pwm_out,     e_pwm);
      check({tag, ".busy"},  k, busy,        e_busy);
      check({tag, ".start"}, k, burst_start, e_start);
      trig = hold | ((k < 64) ? pulses[k] : 1'b0);
      if (k == en_drop_k) enable = 1'b0;
      tick();
    end
  endtask

  // Raise trig and confirm nothing happens until the detector sees the edge.
  task automatic fire_trig(input string tag);
    trig = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      tick();
      check_idle({tag, ".lat"}, i);
    end
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    continuous = 1'b0;
    trig       = 1'b0;

    #2;
    check_idle("reset", 0);
    #10 rst_n = 1'b1;
    tick();
    tick();
    check_idle("post_reset", 0);

    // Trig edge while disabled must not start anything.
    trig = 1'b1;
    repeat (LAT + 2) tick();
    check_idle("disabled_trig", 0);
    trig = 1'b0;
    repeat (LAT + 2) tick();

    // Single-shot burst.
    enable = 1'b1;
    fire_trig("single");
    window("single", 40, 1'b0, 1'b0, 64'd0, -1);

    // Retrigger during burst, during gap, and on the gap-exit edge.
    fire_trig("retrig");
    window("retrig", 50, 1'b0, 1'b0,
           (64'd1 << 6) | (64'd1 << 28) | (64'd1 << (TOTAL - 1 - LAT)), -1);

    // trig held high for 100 clocks gives one burst only.
    fire_trig("hold");
    window("hold", 100, 1'b0, 1'b1, 64'd0, -1);
    trig = 1'b0;
    repeat (LAT + 2) tick();
    check_idle("hold_end", 0);

    // Reset asserted between edges at clock 9 of a burst.
    fire_trig("rst_mid");
    window("rst_mid", 9, 1'b0, 1'b0, 64'd0, -1);
    check("rst_mid.pre_pwm", 9, pwm_out, 1'b1);
    check("rst_mid.pre_busy", 9, busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_mid.async", 9);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("rst_mid.after", i);
    end

    // Continuous mode: back-to-back bursts, then enable drops mid-burst.
    continuous = 1'b1;
    tick();
    window("cont", 2 * TOTAL, 1'b1, 1'b0, 64'd0, -1);
    window("en_drop", 45, 1'b0, 1'b0, 64'd0, 5);
    continuous = 1'b0;
    enable     = 1'b1;
    tick();
    check_idle("final", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_tone_gen.md
Name: burst_tone_gen

Overview:
Generates the gated square-wave transducer drive that feeds the phased-delay shift-register chain, in place of the external Arduino PWM.
- Each burst is BURST_CYCLES full cycles of a fixed-frequency tone (40 kHz at 50 MHz by default), followed by a quiet gap.
- Bursts start on a trigger edge (single-shot) or repeat back-to-back (continuous).
- pwm_out connects directly to the delay chain input; busy and burst_start go to status logic.

Parameters:
HALF_PERIOD, 625, clocks per half tone cycle (>=2); default gives 40 kHz at 50 MHz
BURST_CYCLES, 8, full tone cycles per burst (>=1)
GAP_CLKS, 500000, quiet clocks after each burst (>=1); default is 10 ms

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous, active-low reset
enable  input  1  permits new bursts; sampled only when a burst may start
continuous  input  1  1 = auto-repeat bursts, 0 = start bursts on trig rising edge
trig  input  1  burst request; rising-edge sensitive
pwm_out  output  1  registered tone drive to the delay chain
busy  output  1  high in BURST and GAP
burst_start  output  1  one-cycle pulse on the cycle pwm_out first rises in a burst

Behaviour:
- Reset (asynchronous, rst_n low): pwm_out=0, busy=0, burst_start=0, state=IDLE, all counters=0, trig history flop=0. Takes effect immediately, including mid-burst.
- Counter widths: $clog2 of each terminal count, minimum 1 bit. All counters are unsigned and never wrap; they are cleared on every state entry.
- trig_rise = trig & ~trig_q, where trig_q is trig registered every cycle.
- State IDLE:
  - pwm_out=0, busy=0.
  - If enable && (continuous || trig_rise) at a clock edge, the same edge sets state=BURST, pwm_out=1, burst_start=1, half_cnt=0, cyc_cnt=0.
- State BURST:
  - half_cnt increments each clock.
  - At half_cnt==HALF_PERIOD-1: pwm_out toggles and half_cnt clears, so each high or low phase lasts exactly HALF_PERIOD clocks.
  - On each high->low toggle, cyc_cnt increments.
  - On the low->high toggle that would begin cycle BURST_CYCLES, instead: pwm_out stays 0, state=GAP, gap_cnt=0.
  - Burst length is exactly 2*HALF_PERIOD*BURST_CYCLES clocks. No truncated half-cycles.
- State GAP:
  - pwm_out=0; gap_cnt increments each clock.
  - At gap_cnt==GAP_CLKS-1, if enable && continuous: go directly to BURST with the same assignments as the IDLE start, including burst_start=1. Repetition period is therefore exactly 2*HALF_PERIOD*BURST_CYCLES+GAP_CLKS.
  - Otherwise at gap_cnt==GAP_CLKS-1: go to IDLE.
- busy: registered; 1 from the edge entering BURST until the edge returning to IDLE.
- Triggers during BURST or GAP are ignored, not queued.
- trig held high produces exactly one burst.
- A trig rising edge on the same edge GAP exits to IDLE is ignored.
- Deasserting enable mid-burst does not truncate the burst: the burst and its gap complete, then IDLE.
- Changing continuous mid-burst takes effect only at the GAP terminal count.
- burst_start is 0 on every cycle other than a burst-start edge.

Optional Feature:
TRIG_SYNC_EN
- Defined: trig passes through a two-flop synchronizer (reset to 0) before edge detection. trig is then asynchronous-safe, and the trigger-to-pwm_out latency grows by 2 clocks.
- Undefined: trig is assumed synchronous to clk and feeds the edge detector directly.
- No other behaviour differs.

Test Plan:
All tests use HALF_PERIOD=4, BURST_CYCLES=3, GAP_CLKS=10.
- Single-shot: enable=1, continuous=0, trig 0->1 sampled at edge N -> pwm_out=1 and burst_start=1 after edge N. pwm_out then shows 3x(4 high, 4 low) = 24 clocks. busy stays high for 34 clocks, then IDLE. Exactly one burst_start pulse.
- Continuous: enable=1, continuous=1 -> burst_start every 34 clocks. pwm_out high 4 clocks / low 4 clocks, 3 cycles per burst, then 10 low. No IDLE cycles between bursts.
- Retrigger and hold:
  - Extra trig pulses during BURST and GAP -> no extra or extended bursts.
  - trig held high for 100 clocks -> exactly one burst.
- Reset mid-burst: rst_n low at clock 9 of a burst -> pwm_out, busy and burst_start 0 immediately, without waiting for a clock. After release, no burst until a new trig edge.
- Enable drop: continuous=1, enable falls mid-burst -> current burst and gap complete, then IDLE with busy=0 and no further burst_start.
- TRIG_SYNC_EN defined: repeat the single-shot test -> pwm_out rises 2 clocks later than without the macro. Waveform otherwise identical.
